// File: rtl/sort_share_ctrl.sv
// Round-robin front end sharing one pipelined 3-input sorter among NREQ requesters.
// Each issue carries its requester ID down a tag pipeline matched to the sorter latency.
`default_nettype none

module sort_share_ctrl #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 4,
  parameter int LAT   = 1,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [3*WIDTH*NREQ-1:0] req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        srt_a,
  output logic [WIDTH-1:0]        srt_b,
  output logic [WIDTH-1:0]        srt_c,
  input  logic [WIDTH-1:0]        srt_no1,
  input  logic [WIDTH-1:0]        srt_no2,
  input  logic [WIDTH-1:0]        srt_no3,
  output logic                    res_valid,
  output logic [IDW-1:0]          res_id,
  output logic [WIDTH-1:0]        res_no1,
  output logic [WIDTH-1:0]        res_no2,
  output logic [WIDTH-1:0]        res_no3,
  output logic                    idle,
  output logic [15:0]             issue_cnt
);

  localparam int TW = 3 * WIDTH;

  logic [IDW-1:0] ptr;
  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] scan;
  logic [TW-1:0]  grant_data;
  logic [LAT:0]   tag_v;
  logic [IDW-1:0] tag_id [0:LAT];

  // Scan upward from the pointer, wrapping at NREQ-1; first valid requester wins.
  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    scan       = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_any && en && !rst && req_valid[scan]) begin
        grant_any = 1'b1;
        grant_idx = scan;
      end
      scan = (scan == IDW'(NREQ - 1)) ? '0 : scan + 1'b1;
    end
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == IDW'(k)) grant_data = req_data[k*TW +: TW];
    end
  end

  assign req_ready = grant_any ? (NREQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      srt_a     <= '0;
      srt_b     <= '0;
      srt_c     <= '0;
      issue_cnt <= '0;
      tag_v     <= '0;
      for (int s = 0; s <= LAT; s++) tag_id[s] <= '0;
    end else begin
      if (grant_any) begin
        ptr       <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        srt_a     <= grant_data[3*WIDTH-1:2*WIDTH];
        srt_b     <= grant_data[2*WIDTH-1:WIDTH];
        srt_c     <= grant_data[WIDTH-1:0];
        issue_cnt <= issue_cnt + 16'd1;
      end
      // Tags advance every edge so they stay aligned with the sorter pipeline.
      for (int s = LAT; s > 0; s--) begin
        tag_v[s]  <= tag_v[s-1];
        tag_id[s] <= tag_id[s-1];
      end
      tag_v[0]  <= grant_any;
      tag_id[0] <= grant_idx;
    end
  end

  assign res_valid = tag_v[LAT];
  assign res_id    = tag_id[LAT];
  assign res_no1   = srt_no1;
  assign res_no2   = srt_no2;
  assign res_no3   = srt_no3;
  assign idle      = ~grant_any & ~(|tag_v);

endmodule

`default_nettype wire

// File: tb/tb_sort_share_ctrl.sv
// Bench for sort_share_ctrl: directed plus randomized steps against a queue-based reference.
`default_nettype none

module tb_sort_share_ctrl;
  localparam int WIDTH = 3;
  localparam int NREQ  = 4;
  localparam int LAT   = 1;
  localparam int IDW   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [35:0] req_data  = '0;
  logic [3:0]  req_ready;
  logic [2:0]  srt_a, srt_b, srt_c;
  logic [2:0]  s_no1 = '0, s_no2 = '0, s_no3 = '0;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [2:0]  res_no1, res_no2, res_no3;
  logic        idle;
  logic [15:0] issue_cnt;

  sort_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .srt_a(srt_a), .srt_b(srt_b), .srt_c(srt_c),
    .srt_no1(s_no1), .srt_no2(s_no2), .srt_no3(s_no3),
    .res_valid(res_valid), .res_id(res_id),
    .res_no1(res_no1), .res_no2(res_no2), .res_no3(res_no3),
    .idle(idle), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  // External one-stage sorter, descending order (no1 = largest).
  always @(posedge clk) begin
    logic [2:0] x, y, z, t;
    x = srt_a; y = srt_b; z = srt_c;
    if (x < y) begin t = x; x = y; y = t; end
    if (y < z) begin t = y; y = z; z = t; end
    if (x < y) begin t = x; x = y; y = t; end
    s_no1 <= x; s_no2 <= y; s_no3 <= z;
  end

  typedef struct {int id; int a; int b; int c; int due;} item_t;
  item_t q[$];
  int    grant_log[$];
  int    rid_log[$];
  int    m_ptr = 0;
  int    m_cnt = 0;
  int    m_a = 0, m_b = 0, m_c = 0;
  int    edge_n = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b, input int c);
    req_data[i*9 +: 9] = {a[2:0], b[2:0], c[2:0]};
  endtask

  // One clock cycle: check outputs against the model, then advance across the edge.
  task automatic cycle();
    int g, j, obs_idx, mx, mn, md;
    item_t it;
    #1;
    g = -1;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    chk("req_ready", {28'd0, req_ready}, (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("idle", {31'd0, idle}, {31'd0, (g < 0 && q.size() == 0)});
    chk("srt_abc", {23'd0, srt_a, srt_b, srt_c}, (m_a << 6) | (m_b << 3) | m_c);
    chk("issue_cnt", {16'd0, issue_cnt}, m_cnt);
    obs_idx = -1;
    for (int k = 0; k < NREQ; k++) if (req_ready[k]) obs_idx = k;
    if (obs_idx >= 0) grant_log.push_back(obs_idx);
    if (q.size() > 0 && q[0].due == edge_n) begin
      it = q.pop_front();
      mx = (it.a > it.b) ? it.a : it.b; mx = (mx > it.c) ? mx : it.c;
      mn = (it.a < it.b) ? it.a : it.b; mn = (mn < it.c) ? mn : it.c;
      md = it.a + it.b + it.c - mx - mn;
      chk("res_valid", {31'd0, res_valid}, 1);
      chk("res_id", {30'd0, res_id}, it.id);
      chk("res_sorted", {23'd0, res_no1, res_no2, res_no3}, (mx << 6) | (md << 3) | mn);
      rid_log.push_back(int'(res_id));
    end else begin
      chk("res_valid_idle", {31'd0, res_valid}, 0);
    end
    @(posedge clk);
    edge_n++;
    if (g >= 0) begin
      it.id = g;
      it.a = int'(req_data[g*9+6 +: 3]);
      it.b = int'(req_data[g*9+3 +: 3]);
      it.c = int'(req_data[g*9 +: 3]);
      it.due = edge_n + LAT;
      q.push_back(it);
      m_a = it.a; m_b = it.b; m_c = it.c;
      m_ptr = (g + 1) % NREQ;
      m_cnt = (m_cnt + 1) % 65536;
    end
    @(negedge clk);
  endtask

  task automatic reset_checks();
    chk("rst_req_ready", {28'd0, req_ready}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_id", {30'd0, res_id}, 0);
    chk("rst_idle", {31'd0, idle}, 1);
    chk("rst_srt", {23'd0, srt_a, srt_b, srt_c}, 0);
    chk("rst_issue_cnt", {16'd0, issue_cnt}, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; model state is discarded with it.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1 reset_checks();
    @(posedge clk);
    #1 reset_checks();
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_ptr = 0; m_cnt = 0; m_a = 0; m_b = 0; m_c = 0;
  endtask

  task automatic drain();
    req_valid = '0;
    repeat (LAT + 3) cycle();
  endtask

  initial begin
    int exp_rr[8];
    int exp_13[3];
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_13 = '{3, 1, 3};

    #1 reset_checks();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Single request from requester 2.
    en = 1'b1;
    set_req(2, 5, 1, 3);
    req_valid = 4'b0100;
    cycle();
    drain();

    // Full contention from pointer 0: strict rotation.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(7), $urandom_range(7), $urandom_range(7));
    grant_log.delete(); rid_log.delete();
    req_valid = 4'b1111;
    repeat (8) cycle();
    drain();
    chk("rr_grant_count", grant_log.size(), 8);
    chk("rr_res_count", rid_log.size(), 8);
    for (int i = 0; i < 8 && i < grant_log.size() && i < rid_log.size(); i++) begin
      chk("rr_grant_order", grant_log[i], exp_rr[i]);
      chk("rr_res_id_order", rid_log[i], exp_rr[i]);
    end

    // Move pointer to 2, then contend between requesters 1 and 3.
    req_valid = 4'b0010;
    cycle();
    grant_log.delete();
    req_valid = 4'b1010;
    repeat (3) cycle();
    chk("r13_count", grant_log.size(), 3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++) chk("r13_order", grant_log[i], exp_13[i]);
    drain();

    // en drops after two handshakes; tags drain, idle returns.
    rid_log.delete();
    req_valid = 4'b1111;
    repeat (2) cycle();
    en = 1'b0;
    repeat (5) cycle();
    chk("en_drop_results", rid_log.size(), 2);
    chk("en_drop_idle", {31'd0, idle}, 1);
    en = 1'b1;
    drain();

    // Reset with two tags in flight, then requester 1 granted at once.
    req_valid = 4'b0101;
    repeat (2) cycle();
    do_reset();
    rid_log.delete();
    req_valid = 4'b0000;
    repeat (3) cycle();
    chk("post_rst_no_results", rid_log.size(), 0);
    set_req(1, 6, 2, 7);
    req_valid = 4'b0010;
    cycle();
    drain();

    // Exhaustive triplets from requester 0, back to back.
    do_reset();
    rid_log.delete();
    req_valid = 4'b0001;
    for (int i = 0; i < 512; i++) begin
      set_req(0, (i >> 6) & 7, (i >> 3) & 7, i & 7);
      cycle();
    end
    drain();
    chk("exh_results", rid_log.size(), 512);
    chk("exh_issue_cnt", {16'd0, issue_cnt}, 512);

    // Randomized traffic with occasional en gaps.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(7) != 0);
      req_valid = 4'($urandom_range(15));
      for (int r = 0; r < NREQ; r++) set_req(r, $urandom_range(7), $urandom_range(7), $urandom_range(7));
      cycle();
    end
    en = 1'b1;
    drain();
    chk("rand_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
